// File: rtl/timing_counter.sv
// Runtime-programmable up/down timing counter for the display sync chain.
// Produces terminal-count trigger, post-wrap pulse and a registered compare window.
module timing_counter #(
    parameter int SIZE         = 10,
    parameter int DEFAULT_MAX  = 799,
    parameter int INIT_VALUE   = DEFAULT_MAX,
    parameter int WIN_POLARITY = 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            ENABLE,
    input  logic            CLEAR,
    input  logic            DOWN,
    input  logic            LOAD_MAX,
    input  logic [SIZE-1:0] MAX_IN,
    input  logic [SIZE-1:0] WIN_START,
    input  logic [SIZE-1:0] WIN_END,
    output logic [SIZE-1:0] TIME_COUNT,
    output logic            TRIGGER_OUT,
    output logic            WRAP_OUT,
    output logic            WINDOW_OUT,
    output logic [SIZE-1:0] MAX_OUT
);

    localparam logic [SIZE-1:0] RST_MAX   = SIZE'(DEFAULT_MAX);
    localparam logic [SIZE-1:0] RST_COUNT = SIZE'(INIT_VALUE);
    localparam logic            WIN_ACT   = (WIN_POLARITY != 0);

    logic [SIZE-1:0] count_q, count_d;
    logic [SIZE-1:0] max_q, max_d;
    logic            trig_q, trig_d;
    logic            wrap_q, wrap_d;
    logic            win_q, win_d;

    logic [SIZE-1:0] start_val;
    logic [SIZE-1:0] terminal_val;
    logic            at_wrap;
    logic            in_win;

    // Out-of-range counts (after max_r shrank) wrap like the terminal value does.
    always_comb begin
        start_val    = DOWN ? max_q : '0;
        terminal_val = DOWN ? '0 : max_q;
        if (DOWN) begin
            at_wrap = (count_q == '0) || (count_q > max_q);
        end else begin
            at_wrap = (count_q >= max_q);
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (CLEAR) begin
            count_d = start_val;
        end else if (ENABLE) begin
            wrap_d = at_wrap;
            if (DOWN) begin
                count_d = at_wrap ? max_q : count_q - SIZE'(1);
            end else begin
                count_d = at_wrap ? '0 : count_q + SIZE'(1);
            end
        end
    end

    always_comb begin
        if (WIN_START <= WIN_END) begin
            in_win = (count_d >= WIN_START) && (count_d <= WIN_END);
        end else begin
            in_win = (count_d >= WIN_START) || (count_d <= WIN_END);
        end
    end

    // A wrap landing on the terminal value (max_r = 0) must not look like a trigger.
    always_comb begin
        trig_d = ENABLE && !CLEAR && (count_d == terminal_val) && !wrap_d;
        win_d  = WIN_ACT ^ ~in_win;
        max_d  = LOAD_MAX ? MAX_IN : max_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= RST_COUNT;
            max_q   <= RST_MAX;
            trig_q  <= 1'b0;
            wrap_q  <= 1'b0;
            win_q   <= ~WIN_ACT;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
            trig_q  <= trig_d;
            wrap_q  <= wrap_d;
            win_q   <= win_d;
        end
    end

    assign TIME_COUNT  = count_q;
    assign TRIGGER_OUT = trig_q;
    assign WRAP_OUT    = wrap_q;
    assign WINDOW_OUT  = win_q;
    assign MAX_OUT     = max_q;

endmodule
